// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 keyboard receiver with byte queue and AXI-Lite read port

module ps2_rx_fifo_filter #(
    parameter int DEBOUNCE_N = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic filt
);
    localparam int CW = (DEBOUNCE_N > 1) ? $clog2(DEBOUNCE_N) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_N - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Two-flop synchronizer, then accept a new level only after DEBOUNCE_N matching samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
            filt <= 1'b1;
            cnt  <= '0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == filt) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                filt <= sync[1];
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module ps2_rx_fifo_queue #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               in_tdata,
    input  logic                     in_tvalid,
    output logic [7:0]               out_tdata,
    output logic                     out_tvalid,
    input  logic                     out_tready,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign out_tvalid = (count != '0);
    assign full       = (count == FULL_CNT);
    assign do_pop     = out_tready & out_tvalid;
    // When full, a same-cycle pop frees the head slot that the write reuses
    assign do_push    = in_tvalid & (~full | do_pop);
    assign overflow   = in_tvalid & full & ~do_pop;
    assign out_tdata  = mem[rd_ptr];

    // Byte storage
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= in_tdata;
    end

    // Pointers wrap naturally at the power-of-two depth; count tells full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 16,
    parameter int DEBOUNCE_N     = 10,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] araddr,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    output logic        irq,
    input  logic        ps2_clk,
    input  logic        ps2_data
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RESP} rd_state_t;

    rd_state_t        state;
    rd_state_t        state_next;
    logic             clk_f;
    logic             data_f;
    logic             clk_prev;
    logic             fall;
    logic [3:0]       bit_idx;
    logic [9:0]       sreg;
    logic [TW-1:0]    to_cnt;
    logic             push_req;
    logic [7:0]       push_byte;
    logic             perr_evt;
    logic             ferr_evt;
    logic             ovr;
    logic             perr;
    logic             ferr;
    logic [7:0]       head;
    logic             not_empty;
    logic             full;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             pop;
    logic             clr_flags;
    logic [15:0]      addr_q;
    logic [31:0]      status;
    logic [31:0]      rd_word;
    logic             unused_prot;

    assign unused_prot = ^arprot;
    assign rresp       = 2'b00;
    assign fall        = clk_prev & ~clk_f;
    assign pop         = (state == LOAD) && (addr_q == 16'h0000);
    assign clr_flags   = (state == LOAD) && (addr_q == 16'h0004);

    ps2_rx_fifo_filter #(.DEBOUNCE_N(DEBOUNCE_N)) u_clk_filt (
        .clk(clk), .rst_n(rst_n), .raw(ps2_clk), .filt(clk_f)
    );

    ps2_rx_fifo_filter #(.DEBOUNCE_N(DEBOUNCE_N)) u_data_filt (
        .clk(clk), .rst_n(rst_n), .raw(ps2_data), .filt(data_f)
    );

    ps2_rx_fifo_queue #(.DEPTH(FIFO_DEPTH)) u_queue (
        .clk(clk), .rst_n(rst_n),
        .in_tdata(push_byte), .in_tvalid(push_req),
        .out_tdata(head), .out_tvalid(not_empty), .out_tready(pop),
        .full(full), .count(count), .overflow(overflow)
    );

    // Frame receiver: shift start..parity in LSB first, judge the frame on the stop-bit edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_prev  <= 1'b1;
            bit_idx   <= '0;
            sreg      <= '0;
            to_cnt    <= '0;
            push_req  <= 1'b0;
            push_byte <= '0;
            perr_evt  <= 1'b0;
            ferr_evt  <= 1'b0;
        end else begin
            clk_prev <= clk_f;
            push_req <= 1'b0;
            perr_evt <= 1'b0;
            ferr_evt <= 1'b0;
            if (fall) begin
                to_cnt <= '0;
                if (bit_idx == 4'd10) begin
                    bit_idx   <= '0;
                    push_byte <= sreg[8:1];
                    if (sreg[0] || !data_f) begin
                        ferr_evt <= 1'b1;
                    end else if (!(^sreg[9:1])) begin
                        perr_evt <= 1'b1;
                    end else begin
                        push_req <= 1'b1;
                    end
                end else begin
                    sreg    <= {data_f, sreg[9:1]};
                    bit_idx <= bit_idx + 4'd1;
                end
            end else if (bit_idx != 4'd0) begin
                if (to_cnt == TO_LAST) begin
                    bit_idx  <= '0;
                    to_cnt   <= '0;
                    ferr_evt <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

    // Sticky error flags: a new event in the clearing cycle keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr  <= 1'b0;
            perr <= 1'b0;
            ferr <= 1'b0;
            irq  <= 1'b0;
        end else begin
            ovr  <= overflow | (ovr  & ~clr_flags);
            perr <= perr_evt | (perr & ~clr_flags);
            ferr <= ferr_evt | (ferr & ~clr_flags);
            irq  <= not_empty | ovr | perr | ferr;
        end
    end

    // Read data selection for the latched address
    always_comb begin
        status              = '0;
        status[0]           = not_empty;
        status[1]           = full;
        status[2]           = ovr;
        status[3]           = perr;
        status[4]           = ferr;
        status[16 +: CNT_W] = count;
        rd_word             = '0;
        if (addr_q == 16'h0000) begin
            if (not_empty) rd_word = {23'b0, 1'b1, head};
        end else if (addr_q == 16'h0004) begin
            rd_word = status;
        end
    end

    // Read FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Read FSM next-state
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (arvalid) state_next = LOAD;
            LOAD:    state_next = RESP;
            RESP:    if (rready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered handshake outputs so everything reads 0 while held in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            addr_q  <= '0;
        end else begin
            arready <= (state_next == IDLE);
            rvalid  <= (state_next == RESP);
            if (state == IDLE && arvalid) addr_q <= araddr;
            if (state == LOAD) rdata <= rd_word;
        end
    end
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - randomized model-checked bench for ps2_rx_fifo

module tb_ps2_rx_fifo;
    localparam int D  = 4;
    localparam int DB = 3;
    localparam int TO = 300;
    localparam int H  = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        irq;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  mq[$];
    bit          m_ovr = 1'b0;
    bit          m_perr = 1'b0;
    bit          m_ferr = 1'b0;
    logic [31:0] exp_rdata = '0;
    bit          quiet = 1'b0;
    logic [31:0] got;
    logic [10:0] f;
    int          r;
    int          k;
    int          a;
    logic [15:0] ad;

    always #5 clk = ~clk;

    ps2_rx_fifo #(.FIFO_DEPTH(D), .DEBOUNCE_N(DB), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .irq(irq), .ps2_clk(ps2_clk), .ps2_data(ps2_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_irq();
        return (mq.size() != 0) || m_ovr || m_perr || m_ferr;
    endfunction

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par,
                                               input bit bad_start, input bit bad_stop);
        logic p;
        p = ~(^b);
        if (bad_par) p = ~p;
        return {~bad_stop, p, b, bad_start};
    endfunction

    task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_start,
                               input bit bad_stop);
        if (bad_start || bad_stop)  m_ferr = 1'b1;
        else if (bad_par)           m_perr = 1'b1;
        else if (mq.size() < D)     mq.push_back(b);
        else                        m_ovr = 1'b1;
    endtask

    task automatic model_read(input logic [15:0] addr, output logic [31:0] e);
        e = '0;
        if (addr == 16'h0000) begin
            if (mq.size() > 0) begin
                e = 32'h100 | {24'b0, mq[0]};
                void'(mq.pop_front());
            end
        end else if (addr == 16'h0004) begin
            e[0]     = (mq.size() != 0);
            e[1]     = (mq.size() == D);
            e[2]     = m_ovr;
            e[3]     = m_perr;
            e[4]     = m_ferr;
            e[24:16] = 9'(mq.size());
            m_ovr  = 1'b0;
            m_perr = 1'b0;
            m_ferr = 1'b0;
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            repeat (H) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (H) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_start,
                              input bit bad_stop);
        quiet = 1'b0;
        send_bits(make_frame(b, bad_par, bad_start, bad_stop), 11);
        model_frame(b, bad_par, bad_start, bad_stop);
        repeat (8) @(negedge clk);
        quiet = 1'b1;
    endtask

    task automatic do_read(input logic [15:0] addr, input int hold, output logic [31:0] data);
        int n;
        logic [31:0] e;
        quiet = 1'b0;
        model_read(addr, e);
        exp_rdata = e;
        @(negedge clk);
        araddr  = addr;
        arprot  = 3'($urandom);
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("arready_handshake", {31'b0, arready}, 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        araddr  = 16'($urandom);
        n = 0;
        while (!rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rvalid_arrives", {31'b0, rvalid}, 32'd1);
        data = rdata;
        repeat (hold) @(negedge clk);
        check("rvalid_held", {31'b0, rvalid}, 32'd1);
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        repeat (3) @(negedge clk);
        quiet = 1'b1;
    endtask

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rst_n) begin
                check("rresp_okay", {30'b0, rresp}, 32'd0);
                if (rvalid) begin
                    check("rdata_resp", rdata, exp_rdata);
                    check("arready_in_resp", {31'b0, arready}, 32'd0);
                end
                if (quiet) begin
                    check("irq_level", {31'b0, irq}, {31'b0, model_irq()});
                    check("arready_idle", {31'b0, arready}, 32'd1);
                    check("rvalid_idle", {31'b0, rvalid}, 32'd0);
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: run still active, required completion within budget");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_arready", {31'b0, arready}, 32'd0);
        check("reset_rvalid", {31'b0, rvalid}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_irq", {31'b0, irq}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("arready_first_edge", {31'b0, arready}, 32'd1);
        repeat (2) @(negedge clk);
        quiet = 1'b1;

        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        check("irq_pending", {31'b0, irq}, 32'd1);
        do_read(16'h0000, 0, got);
        check("data_1c", got, 32'h0000_011C);
        check("irq_after_pop", {31'b0, irq}, 32'd0);
        do_read(16'h0000, 1, got);
        check("data_empty", got, 32'h0000_0000);

        send_frame(8'h2B, 1'b1, 1'b0, 1'b0);
        send_frame(8'h44, 1'b0, 1'b0, 1'b1);
        do_read(16'h0004, 0, got);
        check("status_perr_ferr", got, 32'h0000_0018);
        do_read(16'h0004, 0, got);
        check("status_cleared", got, 32'h0000_0000);

        for (int i = 0; i < D + 1; i++) send_frame(8'(8'hA1 + i), 1'b0, 1'b0, 1'b0);
        do_read(16'h0004, 2, got);
        check("status_full_ovr", got, 32'h0004_0007);
        for (int i = 0; i < D; i++) begin
            do_read(16'h0000, 0, got);
            check("data_order", got, 32'h100 | 32'(8'hA1 + i));
        end
        do_read(16'h0004, 0, got);
        check("status_drained", got, 32'h0000_0000);

        quiet = 1'b0;
        f = make_frame(8'h99, 1'b0, 1'b0, 1'b0);
        send_bits(f, 4);
        repeat (TO + 30) @(negedge clk);
        m_ferr = 1'b1;
        quiet = 1'b1;
        do_read(16'h0004, 0, got);
        check("status_timeout", got, 32'h0000_0010);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        do_read(16'h0000, 0, got);
        check("data_5a", got, 32'h0000_015A);

        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        do_read(16'h0000, 10, got);
        check("data_3c_held", got, 32'h0000_013C);
        do_read(16'h0000, 0, got);
        check("single_pop", got, 32'h0000_0000);

        send_frame(8'h33, 1'b0, 1'b0, 1'b0);
        quiet = 1'b0;
        f = make_frame(8'h77, 1'b0, 1'b0, 1'b0);
        send_bits(f, 5);
        @(negedge clk);
        ps2_data = f[5];
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_arready", {31'b0, arready}, 32'd0);
        check("midreset_rvalid", {31'b0, rvalid}, 32'd0);
        check("midreset_rdata", rdata, 32'd0);
        check("midreset_irq", {31'b0, irq}, 32'd0);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        mq.delete();
        m_ovr  = 1'b0;
        m_perr = 1'b0;
        m_ferr = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arready_after_midreset", {31'b0, arready}, 32'd1);
        repeat (3) @(negedge clk);
        quiet = 1'b1;
        do_read(16'h0004, 0, got);
        check("status_after_reset", got, 32'h0000_0000);
        send_frame(8'h77, 1'b0, 1'b0, 1'b0);
        do_read(16'h0000, 0, got);
        check("data_77", got, 32'h0000_0177);

        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            if (r < 5) begin
                k = $urandom_range(0, 19);
                send_frame(8'($urandom), k < 2, k == 2, k == 3);
            end else begin
                a = $urandom_range(0, 9);
                if (a < 5)      ad = 16'h0000;
                else if (a < 8) ad = 16'h0004;
                else begin
                    ad = 16'($urandom_range(1, 65535));
                    if (ad == 16'h0004) ad = 16'h0008;
                end
                do_read(ad, $urandom_range(0, 5), got);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
